operand_collector: RTL and testbench

Upstream stage of the 64-bit ripple-carry adder. Assembles the byte stream delivered by the UART receiver into two little-endian operands and presents them to the adder with a valid/ready handshake. Also provides inter-byte timeout resynchronisation and overrun detection so that a lost byte cannot permanently misalign later frames.

---
 rtl/operand_collector.sv | 83 ++++++++
 tb/tb_operand_collector.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/operand_collector.sv
// operand_collector: assembles a UART byte stream into two little-endian operands for the adder,
// with valid/ready hand-off, inter-byte timeout resync and overrun detection.
module operand_collector #(
    parameter int BYTES_PER_OPERAND = 8,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [7:0]                     rx_data_i,
    input  logic                           rx_valid_i,
    output logic [8*BYTES_PER_OPERAND-1:0] a_o,
    output logic [8*BYTES_PER_OPERAND-1:0] b_o,
    output logic                           cin_o,
    output logic                           op_valid_o,
    input  logic                           op_ready_i,
    output logic                           busy_o,
    output logic                           overrun_o,
    output logic                           timeout_o
);
    localparam int KW = BYTES_PER_OPERAND > 1 ? $clog2(BYTES_PER_OPERAND) : 1;
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(BYTES_PER_OPERAND - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = TIMEOUT_CYCLES > 0;

    typedef enum logic [1:0] {COLLECT_A, COLLECT_B, HOLD} state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [TW-1:0] idle;
    logic [KW+2:0] ofs;
    logic          partial;
    logic          abort;

    assign ofs     = {k, 3'b000};
    assign partial = (state == COLLECT_A && k != '0) || state == COLLECT_B;
    assign abort   = TO_EN && partial && !rx_valid_i && idle == T_LAST;
    assign busy_o  = state != COLLECT_A || k != '0;
    assign cin_o   = 1'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= COLLECT_A;
            k          <= '0;
            idle       <= '0;
            a_o        <= '0;
            b_o        <= '0;
            op_valid_o <= 1'b0;
            overrun_o  <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            overrun_o <= state == HOLD && rx_valid_i && !op_ready_i;
            timeout_o <= abort;
            idle      <= (partial && !rx_valid_i && !abort) ? idle + 1'b1 : '0;
            case (state)
                COLLECT_A, COLLECT_B: begin
                    if (rx_valid_i) begin
                        if (state == COLLECT_A) a_o[ofs +: 8] <= rx_data_i;
                        else b_o[ofs +: 8] <= rx_data_i;
                        k <= k == K_LAST ? '0 : k + 1'b1;
                        if (k == K_LAST) begin
                            state      <= state == COLLECT_A ? COLLECT_B : HOLD;
                            op_valid_o <= state == COLLECT_B;
                        end
                    end else if (abort) begin
                        state <= COLLECT_A;
                        k     <= '0;
                    end
                end
                HOLD: begin
                    // a byte on the handshake edge becomes byte 0 of the next A
                    if (op_ready_i) begin
                        op_valid_o <= 1'b0;
                        state      <= (rx_valid_i && K_LAST == '0) ? COLLECT_B : COLLECT_A;
                        k          <= (rx_valid_i && K_LAST != '0) ? KW'(1) : '0;
                        if (rx_valid_i) a_o[7:0] <= rx_data_i;
                    end
                end
                default: state <= COLLECT_A;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_collector.sv
// tb_operand_collector: directed and random byte streams checked against a frame-level byte-queue model.
module tb_operand_collector;
    localparam int B = 8;
    localparam int T = 16;

    logic        clk = 0;
    logic        rst_n = 0;
    logic [7:0]  rd = 0;
    logic        rv = 0;
    logic        rdy = 0;
    logic [63:0] a, b;
    logic        cin, valid, busy, ovr, to;

    operand_collector #(.BYTES_PER_OPERAND(B), .TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rd), .rx_valid_i(rv),
        .a_o(a), .b_o(b), .cin_o(cin), .op_valid_o(valid), .op_ready_i(rdy),
        .busy_o(busy), .overrun_o(ovr), .timeout_o(to)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ovr_cnt = 0;
    int to_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: a frame is just a count of bytes received so far plus the bytes themselves.
    int         n = 0;
    int         idle = 0;
    logic [7:0] mb [2*B];
    bit         e_ovr = 0;
    bit         e_to = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; idle = 0; e_ovr = 0; e_to = 0;
            foreach (mb[i]) mb[i] = 0;
        end else begin
            e_ovr = 0; e_to = 0;
            if (n == 2*B) begin
                if (rdy) begin
                    n = 0;
                    if (rv) begin mb[0] = rd; n = 1; end
                end else if (rv) e_ovr = 1;
            end else if (rv) begin
                mb[n] = rd; n++;
            end else if (n > 0) begin
                if (idle == T-1) begin n = 0; e_to = 1; end
                else idle++;
            end
            if (rv || n == 0 || n == 2*B || e_to) idle = 0;
        end
    end

    function automatic logic [63:0] model_op(input int base);
        logic [63:0] r;
        for (int i = 0; i < B; i++) r[8*i +: 8] = mb[base + i];
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cin", cin, 0);
            chk("op_valid", valid, n == 2*B);
            chk("busy", busy, n != 0);
            chk("overrun", ovr, e_ovr);
            chk("timeout", to, e_to);
            if (n == 2*B) begin
                chk("a_o", a, model_op(0));
                chk("b_o", b, model_op(B));
            end
            if (ovr) ovr_cnt++;
            if (to) to_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        rv = 1; rd = d;
        tick();
        rv = 0;
    endtask

    task automatic send_bytes(input logic [127:0] f, input int from, input int upto);
        for (int i = from; i < upto; i++) send(f[8*i +: 8]);
    endtask

    task automatic idle_ticks(input int c);
        rv = 0;
        repeat (c) tick();
    endtask

    logic [127:0] f;
    int           ob;

    initial begin
        #2;
        chk("rst_a", a, 0); chk("rst_b", b, 0); chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0); chk("rst_ovr", ovr, 0); chk("rst_to", to, 0);
        @(negedge clk); rst_n = 1;
        tick();

        // single frame, ready held high
        rdy = 1;
        send_bytes({64'd20, 64'd20}, 0, 16);
        chk("t1_valid", valid, 1); chk("t1_a", a, 20); chk("t1_b", b, 20);
        chk("t1_sum", a + b, 40);
        tick();
        chk("t1_valid_1cyc", valid, 0);

        // overrun during HOLD
        rdy = 0;
        send_bytes({64'd20, 64'd20}, 0, 16);
        send(8'hAA);
        chk("t2_ovr", ovr, 1); chk("t2_a", a, 20); chk("t2_b", b, 20); chk("t2_valid", valid, 1);
        tick();
        chk("t2_ovr_pulse", ovr, 0);
        rdy = 1;
        tick();
        chk("t2_valid_done", valid, 0); chk("t2_busy", busy, 0);

        // timeout after 5 bytes
        send_bytes({64'd7, 64'd7}, 0, 5);
        idle_ticks(15);
        chk("t3_no_to_yet", to, 0); chk("t3_busy", busy, 1);
        tick();
        chk("t3_to", to, 1); chk("t3_busy_fall", busy, 0);
        tick();
        chk("t3_to_pulse", to, 0);
        send_bytes({64'd1000, 64'd1000}, 0, 16);
        chk("t3_a", a, 1000); chk("t3_b", b, 1000);
        tick();

        // byte on 16th idle cycle saves the frame
        ob = to_cnt;
        f = {64'h1122334455667788, 64'h0807060504030201};
        send_bytes(f, 0, 5);
        idle_ticks(15);
        send_bytes(f, 5, 16);
        chk("t4_valid", valid, 1);
        chk("t4_a", a, 64'h0807060504030201); chk("t4_b", b, 64'h1122334455667788);
        chk("t4_no_to", to_cnt, ob);
        tick();

        // byte on the handshake cycle starts the next frame
        rdy = 0;
        send_bytes({64'd5, 64'd9}, 0, 16);
        ob = ovr_cnt;
        rdy = 1;
        send(8'h01);
        chk("t5_valid_drop", valid, 0); chk("t5_busy", busy, 1);
        send_bytes({64'd1, 64'd1}, 1, 16);
        chk("t5_valid", valid, 1); chk("t5_a", a, 1); chk("t5_b", b, 1);
        chk("t5_no_ovr", ovr_cnt, ob);
        tick();

        // asynchronous reset mid-frame
        send_bytes({64'd3, 64'd3}, 0, 10);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk("t6_a", a, 0); chk("t6_b", b, 0); chk("t6_valid", valid, 0);
        chk("t6_busy", busy, 0); chk("t6_ovr", ovr, 0); chk("t6_to", to, 0); chk("t6_cin", cin, 0);
        @(negedge clk); rst_n = 1;
        tick();
        send_bytes({128{1'b1}}, 0, 16);
        chk("t6_ff_a", a, 64'hFFFF_FFFF_FFFF_FFFF); chk("t6_ff_b", b, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();

        // random traffic with random backpressure and occasional long gaps
        for (int i = 0; i < 1500; i++) begin
            rv  = $urandom_range(0, 99) < 70;
            rd  = 8'($urandom);
            rdy = $urandom_range(0, 99) < 60;
            tick();
            if ($urandom_range(0, 59) == 0) idle_ticks(T + 2);
        end
        rv = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
